// File: rtl/wbu_commit_arbiter_if.sv
// Writeback/commit bundle between the two issue ways, the commit arbiter and the
// integer register-file write port.
interface wbu_commit_arbiter_if;
  logic        way0_valid_i;
  logic        way0_rdWriteEnable_i;
  logic [4:0]  way0_rdAddr_i;
  logic [63:0] way0_rdData_i;
  logic [1:0]  way0_pID_i;
  logic        way0_ready_o;

  logic        way1_valid_i;
  logic        way1_rdWriteEnable_i;
  logic [4:0]  way1_rdAddr_i;
  logic [63:0] way1_rdData_i;
  logic [1:0]  way1_pID_i;
  logic        way1_ready_o;

  logic        flush_i;
  logic [1:0]  flushPID_i;

  logic        rfWriteEnable_o;
  logic [4:0]  rfAddr_o;
  logic [63:0] rfData_o;
  logic        commitValid_o;
  logic [1:0]  commitPID_o;
  logic        error_o;

  // Arbiter side.
  modport slave (
    input  way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    input  way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    input  flush_i, flushPID_i,
    output way0_ready_o, way1_ready_o,
    output rfWriteEnable_o, rfAddr_o, rfData_o, commitValid_o, commitPID_o, error_o
  );

  // Core side: writeback producers and register-file consumer.
  modport master (
    output way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    output way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    output flush_i, flushPID_i,
    input  way0_ready_o, way1_ready_o,
    input  rfWriteEnable_o, rfAddr_o, rfData_o, commitValid_o, commitPID_o, error_o
  );
endinterface

// File: rtl/wbu_commit_arbiter.sv
// In-order commit arbiter: two 2-entry writeback FIFOs drained one entry per cycle
// into the register-file write port strictly in program-order ID sequence.
module wbu_commit_arbiter #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  wbu_commit_arbiter_if.slave  bus
);

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  pid;
  } wb_entry_t;

  localparam logic [7:0] STALL_LIMIT_W = 8'(STALL_LIMIT);

  wb_entry_t  fifo_mem [2][2];
  logic [1:0] fifo_count [2];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;

  wb_entry_t  in_entry [2];
  logic [1:0] in_valid;
  logic [1:0] ready;
  logic [1:0] enq;
  logic [1:0] pop;
  logic [1:0] head_valid;
  logic [1:0] head_match;
  wb_entry_t  head [2];

  logic [1:0]  next_pid;
  logic [7:0]  stall_cnt;
  logic [7:0]  stall_next;
  logic        commit;
  logic        duplicate;
  logic        stall_hit;
  wb_entry_t   commit_entry;

  logic        rf_we_q;
  logic [4:0]  rf_addr_q;
  logic [63:0] rf_data_q;
  logic        commit_valid_q;
  logic [1:0]  commit_pid_q;
  logic        error_q;

  assign in_valid[0] = bus.way0_valid_i;
  assign in_valid[1] = bus.way1_valid_i;
  assign in_entry[0] = '{we: bus.way0_rdWriteEnable_i, addr: bus.way0_rdAddr_i,
                         data: bus.way0_rdData_i, pid: bus.way0_pID_i};
  assign in_entry[1] = '{we: bus.way1_rdWriteEnable_i, addr: bus.way1_rdAddr_i,
                         data: bus.way1_rdData_i, pid: bus.way1_pID_i};

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      ready[w]      = (fifo_count[w] != 2'd2) && !reset && !bus.flush_i;
      enq[w]        = in_valid[w] && ready[w];
      head_valid[w] = (fifo_count[w] != 2'd0);
      head[w]       = fifo_mem[w][rd_ptr[w]];
      head_match[w] = head_valid[w] && (head[w].pid == next_pid);
    end
  end

  // Way0 wins whenever its head matches; a simultaneous way1 match is a duplicate pID.
  always_comb begin
    commit       = head_match[0] || head_match[1];
    duplicate    = head_match[0] && head_match[1];
    commit_entry = head_match[0] ? head[0] : head[1];
    pop[0]       = head_match[0] && !bus.flush_i;
    pop[1]       = head_match[1] && !head_match[0] && !bus.flush_i;
  end

  always_comb begin
    stall_next = stall_cnt;
    if (commit || !(head_valid[0] || head_valid[1])) begin
      stall_next = 8'd0;
    end else if (stall_cnt != 8'hFF) begin
      stall_next = stall_cnt + 8'd1;
    end
    stall_hit = (stall_next >= STALL_LIMIT_W);
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (enq[w]) begin
        fifo_mem[w][wr_ptr[w]] <= in_entry[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      for (int w = 0; w < 2; w++) begin
        fifo_count[w] <= 2'd0;
      end
      rd_ptr <= 2'b00;
      wr_ptr <= 2'b00;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (enq[w]) begin
          wr_ptr[w] <= ~wr_ptr[w];
        end
        if (pop[w]) begin
          rd_ptr[w] <= ~rd_ptr[w];
        end
        unique case ({enq[w], pop[w]})
          2'b10:   fifo_count[w] <= fifo_count[w] + 2'd1;
          2'b01:   fifo_count[w] <= fifo_count[w] - 2'd1;
          default: fifo_count[w] <= fifo_count[w];
        endcase
      end
    end
  end

  // Flush outranks commit; the error flag survives it and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pid       <= 2'd0;
      stall_cnt      <= 8'd0;
      rf_we_q        <= 1'b0;
      rf_addr_q      <= 5'd0;
      rf_data_q      <= 64'd0;
      commit_valid_q <= 1'b0;
      commit_pid_q   <= 2'd0;
      error_q        <= 1'b0;
    end else if (bus.flush_i) begin
      next_pid       <= bus.flushPID_i;
      stall_cnt      <= 8'd0;
      rf_we_q        <= 1'b0;
      commit_valid_q <= 1'b0;
    end else begin
      stall_cnt <= stall_next;
      if (duplicate || stall_hit) begin
        error_q <= 1'b1;
      end
      if (commit) begin
        next_pid       <= next_pid + 2'd1;
        commit_valid_q <= 1'b1;
        commit_pid_q   <= commit_entry.pid;
        rf_we_q        <= commit_entry.we && (commit_entry.addr != 5'd0);
        rf_addr_q      <= commit_entry.addr;
        rf_data_q      <= commit_entry.data;
      end else begin
        commit_valid_q <= 1'b0;
        rf_we_q        <= 1'b0;
      end
    end
  end

  assign bus.way0_ready_o    = ready[0];
  assign bus.way1_ready_o    = ready[1];
  assign bus.rfWriteEnable_o = rf_we_q;
  assign bus.rfAddr_o        = rf_addr_q;
  assign bus.rfData_o        = rf_data_q;
  assign bus.commitValid_o   = commit_valid_q;
  assign bus.commitPID_o     = commit_pid_q;
  assign bus.error_o         = error_q;

endmodule

// File: tb/tb_wbu_commit_arbiter.sv
// Self-checking bench for wbu_commit_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based commit model.
module tb_wbu_commit_arbiter;

  localparam int STALL_LIMIT = 15;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wbu_commit_arbiter_if bus ();

  wbu_commit_arbiter #(.STALL_LIMIT(STALL_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [4:0]  addr;
    bit [63:0] data;
    bit [1:0]  pid;
  } ent_t;

  // Reference model: one queue per way, retiring whichever head carries the expected pID.
  ent_t      mq0[$];
  ent_t      mq1[$];
  int        mNextPid;
  int        mStall;
  bit        mErr;
  bit        mCv;
  bit        mWe;
  bit [4:0]  mAddr;
  bit [63:0] mData;
  bit [1:0]  mPid;

  typedef struct {
    int v0, we0, a0; longint unsigned d0; int p0;
    int v1, we1, a1; longint unsigned d1; int p1;
    int flush, fpid;
    int ecv, ewe, eaddr; longint unsigned edata; int epid, eerr;
  } vec_t;

  vec_t vecs [10];
  int   got[$];
  int   expWrap [6];
  int   genPid;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelEdge();
    ent_t e, n0, n1;
    bit h0, h1, buffered, acc0, acc1;
    if (reset) begin
      mq0.delete(); mq1.delete();
      mNextPid = 0; mStall = 0; mErr = 0;
      mCv = 0; mWe = 0; mAddr = 0; mData = 0; mPid = 0;
    end else if (bus.flush_i) begin
      mq0.delete(); mq1.delete();
      mNextPid = int'(bus.flushPID_i);
      mStall = 0; mCv = 0; mWe = 0;
    end else begin
      n0 = '{bus.way0_rdWriteEnable_i, bus.way0_rdAddr_i, bus.way0_rdData_i, bus.way0_pID_i};
      n1 = '{bus.way1_rdWriteEnable_i, bus.way1_rdAddr_i, bus.way1_rdData_i, bus.way1_pID_i};
      acc0 = bus.way0_valid_i && (mq0.size() < 2);
      acc1 = bus.way1_valid_i && (mq1.size() < 2);
      h0 = (mq0.size() > 0) && (int'(mq0[0].pid) == mNextPid);
      h1 = (mq1.size() > 0) && (int'(mq1[0].pid) == mNextPid);
      buffered = (mq0.size() > 0) || (mq1.size() > 0);
      if (h0 && h1) mErr = 1;
      if (h0 || h1) begin
        if (h0) e = mq0.pop_front();
        else    e = mq1.pop_front();
        mCv = 1; mPid = e.pid; mWe = e.we && (e.addr != 0);
        mAddr = e.addr; mData = e.data;
        mNextPid = (mNextPid + 1) % 4;
        mStall = 0;
      end else begin
        mCv = 0; mWe = 0;
        if (!buffered) mStall = 0;
        else begin
          if (mStall < 255) mStall++;
          if (mStall >= STALL_LIMIT) mErr = 1;
        end
      end
      if (acc0) mq0.push_back(n0);
      if (acc1) mq1.push_back(n1);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic runCycle();
    #1;
    checkOutput("model_ready0", 64'(bus.way0_ready_o), 64'((mq0.size() < 2) && !reset && !bus.flush_i));
    checkOutput("model_ready1", 64'(bus.way1_ready_o), 64'((mq1.size() < 2) && !reset && !bus.flush_i));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("model_commitValid", 64'(bus.commitValid_o), 64'(mCv));
    checkOutput("model_rfWriteEnable", 64'(bus.rfWriteEnable_o), 64'(mWe));
    checkOutput("model_rfAddr", 64'(bus.rfAddr_o), 64'(mAddr));
    checkOutput("model_rfData", bus.rfData_o, mData);
    checkOutput("model_error", 64'(bus.error_o), 64'(mErr));
    if (mCv) checkOutput("model_commitPID", 64'(bus.commitPID_o), 64'(mPid));
  endtask

  task automatic clearInputs();
    bus.way0_valid_i = 0; bus.way0_rdWriteEnable_i = 0; bus.way0_rdAddr_i = 0;
    bus.way0_rdData_i = 0; bus.way0_pID_i = 0;
    bus.way1_valid_i = 0; bus.way1_rdWriteEnable_i = 0; bus.way1_rdAddr_i = 0;
    bus.way1_rdData_i = 0; bus.way1_pID_i = 0;
    bus.flush_i = 0; bus.flushPID_i = 0;
  endtask

  task automatic applyStimulus(input int way, input int v, input int we, input int addr,
                               input longint unsigned data, input int pid);
    if (way == 0) begin
      bus.way0_valid_i = v[0]; bus.way0_rdWriteEnable_i = we[0];
      bus.way0_rdAddr_i = addr[4:0]; bus.way0_rdData_i = data; bus.way0_pID_i = pid[1:0];
    end else begin
      bus.way1_valid_i = v[0]; bus.way1_rdWriteEnable_i = we[0];
      bus.way1_rdAddr_i = addr[4:0]; bus.way1_rdData_i = data; bus.way1_pID_i = pid[1:0];
    end
  endtask

  task automatic applyFlush(input int fpid);
    bus.flush_i = 1'b1;
    bus.flushPID_i = fpid[1:0];
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    mq0.delete(); mq1.delete();
    mNextPid = 0; mStall = 0; mErr = 0; mCv = 0; mWe = 0; mAddr = 0; mData = 0; mPid = 0;

    // {way0 v,we,addr,data,pid | way1 v,we,addr,data,pid | flush,fpid | exp cv,we,addr,data,pid,err}
    vecs[0] = '{1,1,5,64'hA5,0,     0,0,0,64'h0,0,       0,0, 0,0,0,64'h0,0,0};
    vecs[1] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       0,0, 1,1,5,64'hA5,0,0};
    vecs[2] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       1,0, 0,0,5,64'hA5,0,0};
    vecs[3] = '{1,1,8,64'h2222,1,   1,1,7,64'h1111,0,    0,0, 0,0,5,64'hA5,0,0};
    vecs[4] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       0,0, 1,1,7,64'h1111,0,0};
    vecs[5] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       0,0, 1,1,8,64'h2222,1,0};
    vecs[6] = '{1,1,0,64'h33,2,     0,0,0,64'h0,0,       0,0, 0,0,8,64'h2222,0,0};
    vecs[7] = '{0,0,0,64'h0,0,      1,0,9,64'h44,3,      0,0, 1,0,0,64'h33,2,0};
    vecs[8] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       0,0, 1,0,9,64'h44,3,0};
    vecs[9] = '{0,0,0,64'h0,0,      0,0,0,64'h0,0,       0,0, 0,0,9,64'h44,0,0};
    expWrap = '{2, 3, 0, 1, 2, 3};

    clearInputs();
    reset = 1'b1;
    runCycle();
    runCycle();
    checkOutput("reset_commitValid", 64'(bus.commitValid_o), 64'd0);
    checkOutput("reset_error", 64'(bus.error_o), 64'd0);
    checkOutput("reset_ready0", 64'(bus.way0_ready_o), 64'd0);
    reset = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      clearInputs();
      applyStimulus(0, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0, vecs[i].p0);
      applyStimulus(1, vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].p1);
      if (vecs[i].flush != 0) applyFlush(vecs[i].fpid);
      runCycle();
      checkOutput($sformatf("vec%0d_commitValid", i), 64'(bus.commitValid_o), 64'(vecs[i].ecv));
      checkOutput($sformatf("vec%0d_rfWriteEnable", i), 64'(bus.rfWriteEnable_o), 64'(vecs[i].ewe));
      checkOutput($sformatf("vec%0d_rfAddr", i), 64'(bus.rfAddr_o), 64'(vecs[i].eaddr));
      checkOutput($sformatf("vec%0d_rfData", i), bus.rfData_o, vecs[i].edata);
      checkOutput($sformatf("vec%0d_error", i), 64'(bus.error_o), 64'(vecs[i].eerr));
      if (vecs[i].ecv != 0)
        checkOutput($sformatf("vec%0d_commitPID", i), 64'(bus.commitPID_o), 64'(vecs[i].epid));
    end

    $display("[TB] stall and flush sequence");
    clearInputs(); applyFlush(1); runCycle();
    clearInputs(); applyStimulus(0, 1, 1, 10, 64'h100, 2); runCycle();
    clearInputs(); applyStimulus(0, 1, 1, 11, 64'h101, 3); runCycle();
    clearInputs();
    #1;
    checkOutput("stall_ready0_full", 64'(bus.way0_ready_o), 64'd0);
    checkOutput("stall_ready1_free", 64'(bus.way1_ready_o), 64'd1);
    repeat (10) runCycle();
    checkOutput("stall_error_early", 64'(bus.error_o), 64'd0);
    checkOutput("stall_no_commit", 64'(bus.commitValid_o), 64'd0);
    repeat (10) runCycle();
    checkOutput("stall_error_raised", 64'(bus.error_o), 64'd1);
    applyFlush(2); runCycle();
    clearInputs();
    checkOutput("flush_error_sticky", 64'(bus.error_o), 64'd1);
    checkOutput("flush_commitValid", 64'(bus.commitValid_o), 64'd0);
    #1;
    checkOutput("flush_ready0_back", 64'(bus.way0_ready_o), 64'd1);
    applyStimulus(0, 1, 1, 12, 64'h102, 2); runCycle();
    clearInputs(); runCycle();
    checkOutput("postflush_commitValid", 64'(bus.commitValid_o), 64'd1);
    checkOutput("postflush_commitPID", 64'(bus.commitPID_o), 64'd2);
    checkOutput("postflush_rfAddr", 64'(bus.rfAddr_o), 64'd12);
    checkOutput("postflush_error", 64'(bus.error_o), 64'd1);

    reset = 1'b1;
    #1;
    checkOutput("reset_mid_ready0", 64'(bus.way0_ready_o), 64'd0);
    runCycle();
    reset = 1'b0;
    checkOutput("reset_mid_error", 64'(bus.error_o), 64'd0);
    checkOutput("reset_mid_rfData", bus.rfData_o, 64'd0);

    $display("[TB] pID wrap sequence");
    clearInputs(); applyFlush(2); runCycle();
    got.delete();
    for (int i = 0; i < 6; i++) begin
      clearInputs();
      applyStimulus(i % 2, 1, 1, 16 + i, 64'h200 + 64'(i), (2 + i) % 4);
      runCycle();
      if (bus.commitValid_o) got.push_back(int'(bus.commitPID_o));
    end
    clearInputs();
    for (int c = 0; c < 8 && got.size() < 6; c++) begin
      runCycle();
      if (bus.commitValid_o) got.push_back(int'(bus.commitPID_o));
    end
    checkOutput("wrap_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      checkOutput($sformatf("wrap_pid%0d", i), 64'(got[i]), 64'(expWrap[i]));
    checkOutput("wrap_error", 64'(bus.error_o), 64'd0);

    $display("[TB] duplicate pID sequence");
    clearInputs(); applyFlush(0); runCycle();
    clearInputs();
    applyStimulus(0, 1, 1, 3, 64'h300, 0);
    applyStimulus(1, 1, 1, 4, 64'h400, 0);
    runCycle();
    clearInputs(); runCycle();
    checkOutput("dup_commitValid", 64'(bus.commitValid_o), 64'd1);
    checkOutput("dup_rfAddr_way0", 64'(bus.rfAddr_o), 64'd3);
    checkOutput("dup_error", 64'(bus.error_o), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("dup_reset_ready1", 64'(bus.way1_ready_o), 64'd0);
    runCycle();
    reset = 1'b0;
    checkOutput("dup_reset_commitValid", 64'(bus.commitValid_o), 64'd0);
    checkOutput("dup_reset_rfAddr", 64'(bus.rfAddr_o), 64'd0);
    checkOutput("dup_reset_commitPID", 64'(bus.commitPID_o), 64'd0);
    checkOutput("dup_reset_error", 64'(bus.error_o), 64'd0);

    $display("[TB] randomized traffic against model");
    genPid = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clearInputs();
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        genPid = 0;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 29) == 0) begin
          applyFlush(int'($urandom_range(0, 3)));
          genPid = int'(bus.flushPID_i);
        end
      end
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(0, 2) != 0) begin
          int pid;
          bit acc;
          pid = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : genPid;
          applyStimulus(w, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                        {$urandom, $urandom}, pid);
          acc = !reset && !bus.flush_i && (((w == 0) ? mq0.size() : mq1.size()) < 2);
          if (acc && pid == genPid) genPid = (genPid + 1) % 4;
        end
      end
      runCycle();
    end
    reset = 1'b0;
    clearInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
